// File: rtl/rgb_window_3x3.sv
// rtl/rgb_window_3x3.sv - streaming 3x3 RGB window generator with two line buffers
//
// Accepts a raster-order RGB pixel stream and emits one 3x3 neighbourhood per
// interior pixel, one cycle after the pixel that completes it.
//
// Ports:
//   i_clk              system clock, rising edge
//   i_rst_n            asynchronous active-low reset
//   i_pixel_data       input pixel {R[23:16], G[15:8], B[7:0]}
//   i_pixel_data_valid one pixel accepted per high cycle
//   o_pixel_data       3x3 window, slot i = row*3+col at bits [i*24 +: 24]
//   o_pixel_data_valid single-cycle window qualifier
//   o_frame_done       pulse after the last pixel of a frame is accepted

module rgb_window_3x3 #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [23:0]  i_pixel_data,
  input  logic         i_pixel_data_valid,
  output logic [215:0] o_pixel_data,
  output logic         o_pixel_data_valid,
  output logic         o_frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  // STREAM exactly while the row counter is at 2 or beyond.
  typedef enum logic {
    FILL,
    STREAM
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [215:0]    win_q, win_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;

  // Line buffers are plain storage (RAM-mappable), deliberately not reset.
  logic [23:0]     lb_a_mem [IMG_WIDTH];
  logic [23:0]     lb_b_mem [IMG_WIDTH];
  logic [23:0]     lb_a_rd;
  logic [23:0]     lb_b_rd;

  logic            accept;
  logic            col_end;
  logic            frame_end;

  assign accept    = i_pixel_data_valid;
  assign col_end   = (col_q == COL_LAST);
  assign frame_end = col_end && (row_q == ROW_LAST);
  assign lb_a_rd   = lb_a_mem[col_q];
  assign lb_b_rd   = lb_b_mem[col_q];

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    valid_d = 1'b0;
    done_d  = 1'b0;

    if (accept) begin
      // Shift every window row left by one column.
      for (int r = 0; r < 3; r++) begin
        win_d[(r*3)*24 +: 24]   = win_q[(r*3+1)*24 +: 24];
        win_d[(r*3+1)*24 +: 24] = win_q[(r*3+2)*24 +: 24];
      end
      // New right-hand column: two rows up, one row up, current pixel.
      win_d[2*24 +: 24] = lb_b_rd;
      win_d[5*24 +: 24] = lb_a_rd;
      win_d[8*24 +: 24] = i_pixel_data;

      // At c = 0,1 the window still holds previous-row columns; never flag it.
      valid_d = (state_q == STREAM) && (col_q >= CW'(2));
      done_d  = frame_end;

      if (col_end) begin
        col_d = '0;
        row_d = frame_end ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end

      if (frame_end) begin
        state_d = FILL;
      end else if (col_end && (row_q == RW'(1))) begin
        state_d = STREAM;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= FILL;
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Both buffers update from their pre-write values at the same column.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      lb_b_mem[col_q] <= lb_a_rd;
      lb_a_mem[col_q] <= i_pixel_data;
    end
  end

  // The window register itself is the output bus, so it holds across gaps.
  assign o_pixel_data       = win_q;
  assign o_pixel_data_valid = valid_q;
  assign o_frame_done       = done_q;

endmodule

// File: tb/tb_rgb_window_3x3.sv
// tb/tb_rgb_window_3x3.sv - randomized self-checking bench for rgb_window_3x3

module tb_rgb_window_3x3;

  localparam int W = 4;
  localparam int H = 4;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic [23:0]  i_pixel_data = '0;
  logic         i_pixel_data_valid = 1'b0;
  logic [215:0] o_pixel_data;
  logic         o_pixel_data_valid;
  logic         o_frame_done;

  rgb_window_3x3 #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_pixel_data      (i_pixel_data),
    .i_pixel_data_valid(i_pixel_data_valid),
    .o_pixel_data      (o_pixel_data),
    .o_pixel_data_valid(o_pixel_data_valid),
    .o_frame_done      (o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference image of the current frame and the raster position of the next pixel.
  logic [23:0]  img [H][W];
  int           mr = 0;
  int           mc = 0;
  logic [215:0] exp_held = '0;
  bit           held_known = 1'b0;

  int           win_cnt = 0;
  int           done_cnt = 0;
  bit           first_taken = 1'b0;
  logic [215:0] first_win = '0;
  logic [215:0] last_win = '0;

  task automatic check_eq(input string tag, input logic [215:0] got, input logic [215:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] dark_min(input logic [215:0] w);
    logic [7:0] m;
    m = 8'hff;
    for (int i = 0; i < 27; i++) if (w[i*8 +: 8] < m) m = w[i*8 +: 8];
    return m;
  endfunction

  task automatic model_reset();
    mr = 0;
    mc = 0;
    held_known = 1'b0;
  endtask

  task automatic send(input logic [23:0] p);
    logic [215:0] w;
    bit ev;
    bit ed;
    img[mr][mc] = p;
    ev = (mr >= 2) && (mc >= 2);
    ed = (mr == H - 1) && (mc == W - 1);
    w  = '0;
    if (ev)
      for (int rr = 0; rr < 3; rr++)
        for (int cc = 0; cc < 3; cc++)
          w[(rr*3+cc)*24 +: 24] = img[mr-2+rr][mc-2+cc];
    i_pixel_data       = p;
    i_pixel_data_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_pixel_data_valid = 1'b0;
    i_pixel_data       = 24'($urandom);
    check_eq("valid", {215'd0, o_pixel_data_valid}, {215'd0, ev});
    check_eq("frame_done", {215'd0, o_frame_done}, {215'd0, ed});
    if (ev) begin
      check_eq("window", o_pixel_data, w);
      check_eq("dark_min", {208'd0, dark_min(o_pixel_data)}, {208'd0, dark_min(w)});
      exp_held   = w;
      held_known = 1'b1;
    end else begin
      held_known = 1'b0;
    end
    if (o_pixel_data_valid) begin
      win_cnt++;
      if (!first_taken) begin
        first_win   = o_pixel_data;
        first_taken = 1'b1;
      end
      last_win = o_pixel_data;
    end
    if (o_frame_done) done_cnt++;
    if (mc == W - 1) begin
      mc = 0;
      mr = (mr == H - 1) ? 0 : mr + 1;
    end else begin
      mc = mc + 1;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      i_pixel_data_valid = 1'b0;
      i_pixel_data       = 24'($urandom);
      @(posedge i_clk);
      #1;
      check_eq("gap_valid", {215'd0, o_pixel_data_valid}, 216'd0);
      check_eq("gap_done", {215'd0, o_frame_done}, 216'd0);
      if (held_known) check_eq("gap_hold", o_pixel_data, exp_held);
    end
  endtask

  // mode 0: coordinate-coded pixels, mode 1: random pixels.
  task automatic send_frame(input int off, input bit gaps, input bit rnd);
    logic [23:0] p;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        p = rnd ? 24'($urandom) : {8'(r), 8'(c), 8'(4*r + c + off)};
        send(p);
        if (gaps) idle(int'($urandom_range(0, 3)));
      end
  endtask

  task automatic clear_stats();
    win_cnt     = 0;
    done_cnt    = 0;
    first_taken = 1'b0;
  endtask

  initial begin
    // Reset held with random activity on the inputs.
    for (int k = 0; k < 5; k++) begin
      i_pixel_data       = 24'($urandom);
      i_pixel_data_valid = 1'($urandom);
      @(posedge i_clk);
      #1;
      check_eq("rst_data", o_pixel_data, 216'd0);
      check_eq("rst_valid", {215'd0, o_pixel_data_valid}, 216'd0);
      check_eq("rst_done", {215'd0, o_frame_done}, 216'd0);
    end
    i_pixel_data_valid = 1'b0;
    i_rst_n = 1'b1;
    model_reset();
    idle(2);

    // Coordinate-coded frame, continuous valid.
    clear_stats();
    send_frame(0, 1'b0, 1'b0);
    check_eq("f1_windows", 216'(win_cnt), 216'((W - 2) * (H - 2)));
    check_eq("f1_done_cnt", 216'(done_cnt), 216'd1);
    check_eq("f1_first_s0", {208'd0, first_win[0*24 +: 8]}, 216'd0);
    check_eq("f1_first_s4", {208'd0, first_win[4*24 +: 8]}, 216'd5);
    check_eq("f1_first_s8", {208'd0, first_win[8*24 +: 8]}, 216'd10);
    check_eq("f1_last_s0", {208'd0, last_win[0*24 +: 8]}, 216'd5);
    check_eq("f1_last_s8", {208'd0, last_win[8*24 +: 8]}, 216'd15);
    idle(2);

    // Same frame with random gaps.
    clear_stats();
    send_frame(0, 1'b1, 1'b0);
    check_eq("f2_windows", 216'(win_cnt), 216'd4);
    check_eq("f2_first_s4", {208'd0, first_win[4*24 +: 8]}, 216'd5);
    check_eq("f2_last_s8", {208'd0, last_win[8*24 +: 8]}, 216'd15);

    // Two back-to-back frames, second offset by 100.
    clear_stats();
    send_frame(0, 1'b0, 1'b0);
    first_taken = 1'b0;
    send_frame(100, 1'b0, 1'b0);
    check_eq("b2b_windows", 216'(win_cnt), 216'd8);
    check_eq("b2b_done_cnt", 216'(done_cnt), 216'd2);
    check_eq("b2b_f2_first_s0", {208'd0, first_win[0*24 +: 8]}, 216'd100);

    // Reset after 7 pixels, then a full frame.
    for (int k = 0; k < 7; k++) send(24'($urandom));
    i_rst_n = 1'b0;
    #2;
    check_eq("midrst_data", o_pixel_data, 216'd0);
    check_eq("midrst_valid", {215'd0, o_pixel_data_valid}, 216'd0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    model_reset();
    clear_stats();
    send_frame(0, 1'b0, 1'b0);
    check_eq("midrst_windows", 216'(win_cnt), 216'd4);
    check_eq("midrst_first_s0", {208'd0, first_win[0*24 +: 8]}, 216'd0);

    // Random pixel frames with random gaps.
    clear_stats();
    for (int f = 0; f < 4; f++) send_frame(0, 1'b1, 1'b1);
    check_eq("rnd_windows", 216'(win_cnt), 216'(4 * (W - 2) * (H - 2)));
    check_eq("rnd_done_cnt", 216'(done_cnt), 216'd4);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
